// File: rtl/sbox_sub_engine.sv
// sbox_sub_engine: iterative AES (Inv)SubBytes over a 128-bit state, LANES bytes per clock.
// Define SBOX_FWD_EN to compile in the forward S-box; without it the engine is inverse-only.
module sbox_sub_engine #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int K  = 16 / LANES;
   localparam int CW = (K > 1) ? $clog2(K) : 1;
   localparam logic [CW-1:0] LAST = CW'(K - 1);

   generate
      if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
         $error("sbox_sub_engine: LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   // Tables are packed with entry 0 in the top byte.
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

`ifdef SBOX_FWD_EN
   localparam logic [2047:0] FWD_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };
`endif

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [7:0]    work     [16];
   logic [7:0]    work_nxt [16];
   logic [3:0]    idx;

   function automatic logic [7:0] lookup(input logic [2047:0] tab, input logic [7:0] b);
      logic [2047:0] sh;
      sh = tab << {b, 3'b000};
      return sh[2047:2040];
   endfunction

`ifdef SBOX_FWD_EN
   logic mode;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode <= 1'b1;
      end else if (state == IDLE && in_valid) begin
         mode <= inv;
      end
   end
`else
   logic unused_inv;
   assign unused_inv = inv;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = RUN;
         RUN:     if (cnt == LAST) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Substitute the LANES-byte window selected by cnt; all other bytes pass through.
   always_comb begin
      work_nxt = work;
      idx      = '0;
      for (int l = 0; l < LANES; l++) begin
         idx = 4'(int'(cnt) * LANES + l);
`ifdef SBOX_FWD_EN
         work_nxt[idx] = mode ? lookup(INV_SBOX, work[idx]) : lookup(FWD_SBOX, work[idx]);
`else
         work_nxt[idx] = lookup(INV_SBOX, work[idx]);
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         for (int k = 0; k < 16; k++) work[k] <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  cnt <= '0;
                  for (int k = 0; k < 16; k++) work[k] <= in_data[127-8*k -: 8];
               end
            end
            RUN: begin
               work <= work_nxt;
               if (cnt != LAST) cnt <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      out_data = '0;
      for (int k = 0; k < 16; k++) out_data[127-8*k -: 8] = work[k];
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule
